// File: rtl/string_stream_pkg.sv
// Shared types and helpers for the string streamer: state encoding,
// default character width and the index-width helper.
package string_stream_pkg;

    // Default bits per character (one byte, ASCII)
    localparam int CW_DEFAULT = 8;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        SEND = 2'd2
    } state_e;

    // Width of a character index for an n-character string (at least 1 bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/string_streamer.sv
// Drains a packed, right-justified string register one character per cycle
// onto a valid/ready byte stream. Leading NUL padding at the MSB end is
// skipped one character per cycle; everything after the first non-NUL
// character (including embedded NULs) is emitted down to character 0.
module string_streamer
    import string_stream_pkg::*;
#(
    parameter int NCHARS = 80,
    parameter int CW     = CW_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [NCHARS*CW-1:0]         load_data,
    output logic                         ch_valid,
    input  logic                         ch_ready,
    output logic [CW-1:0]                ch_data,
    output logic                         ch_last,
    output logic                         busy,
    output logic [$clog2(NCHARS+1)-1:0]  sent
);

    localparam int IW = idx_width(NCHARS);
    localparam int SW = $clog2(NCHARS + 1);

    localparam logic [IW-1:0] IDX_TOP  = IW'(NCHARS - 1);
    localparam logic [IW-1:0] IDX_ZERO = '0;
    localparam logic [SW-1:0] SENT_MAX = SW'(NCHARS);

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [SW-1:0]          sent_q, sent_d;
    logic [NCHARS*CW-1:0]   str_q;
    logic                   ready_q;
    logic                   load_en;
    logic [CW-1:0]          cur_char;

    // Character currently pointed at by idx (inline mux over the string)
    assign cur_char = str_q[int'(idx_q) * CW +: CW];

    // State, index and count registers; async reset returns to idle values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= IDX_TOP;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sent_q  <= sent_d;
        end
    end

    // Out-of-reset flag: holds load_ready low until the first edge after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // String capture; contents are only meaningful after an accepted load
    always_ff @(posedge clk) begin
        if (load_en) begin
            str_q <= load_data;
        end
    end

    // Next-state logic: load in IDLE, skip leading NULs, then stream
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sent_d  = sent_q;
        load_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid && ready_q) begin
                    load_en = 1'b1;
                    idx_d   = IDX_TOP;
                    sent_d  = '0;
                    state_d = SKIP;
                end
            end
            SKIP: begin
                if (cur_char != '0) begin
                    state_d = SEND;
                end else if (idx_q != IDX_ZERO) begin
                    idx_d = idx_q - IW'(1);
                end else begin
                    // Whole string was padding: nothing to send
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (ch_ready) begin
                    if (sent_q != SENT_MAX) begin
                        sent_d = sent_q + SW'(1);
                    end
                    if (idx_q == IDX_ZERO) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state/index only, so ready/valid inputs never
    // reach an output combinationally and ch_data is stable while stalled
    always_comb begin
        load_ready = ready_q && (state_q == IDLE);
        busy       = (state_q != IDLE);
        ch_valid   = (state_q == SEND);
        ch_data    = (state_q == SEND) ? cur_char : '0;
        ch_last    = (state_q == SEND) && (idx_q == IDX_ZERO);
        sent       = sent_q;
    end

endmodule

// File: tb/tb_string_streamer.sv
// Directed bench for string_streamer with a byte scoreboard: expected
// characters are queued when a string is loaded and popped on each beat.
module tb_string_streamer;

    localparam int NCHARS = 80;
    localparam int CW     = 8;
    localparam int NB     = NCHARS * CW;
    localparam int SW     = $clog2(NCHARS + 1);

    logic            clk;
    logic            rst;
    logic            load_valid;
    logic            load_ready;
    logic [NB-1:0]   load_data;
    logic            ch_valid;
    logic            ch_ready;
    logic [CW-1:0]   ch_data;
    logic            ch_last;
    logic            busy;
    logic [SW-1:0]   sent;

    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    logic [CW:0]     exp_q[$];
    logic [CW:0]     e_mon;
    logic            prev_stall = 1'b0;
    logic [CW-1:0]   prev_data = '0;
    logic            bp_en = 1'b0;
    int              bp_ph = 0;

    string_streamer #(.NCHARS(NCHARS), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .ch_valid   (ch_valid),
        .ch_ready   (ch_ready),
        .ch_data    (ch_data),
        .ch_last    (ch_last),
        .busy       (busy),
        .sent       (sent)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] pack_str(input string s);
        logic [NB-1:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r[(s.len() - 1 - i) * CW +: CW] = s[i];
        return r;
    endfunction

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back({1'(i == s.len() - 1), 8'(s[i])});
    endtask

    // Consumer backpressure: ready pattern 1,0,0 repeating when enabled
    initial begin
        ch_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                ch_ready = (bp_ph == 0);
                bp_ph = (bp_ph + 1) % 3;
            end else begin
                ch_ready = 1'b1;
            end
        end
    end

    // Beat monitor: scoreboard compare on handshake, hold check while stalled
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(ch_valid), 32'd1);
                chk("hold_data", 32'(ch_data), 32'(prev_data));
            end
            if (ch_valid && ch_ready) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e_mon = exp_q.pop_front();
                    $display("beat: data=0x%02h last=%0d sent=%0d", ch_data, ch_last, sent);
                    chk("beat_last_data", 32'({ch_last, ch_data}), 32'(e_mon));
                end
            end
            prev_stall = ch_valid && !ch_ready;
            prev_data  = ch_data;
        end
    end

    task automatic do_load(input logic [NB-1:0] d, output int e_cyc);
        logic ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        load_data  = d;
        load_valid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (load_ready) ok = 1'b1;
        end
        chk("load_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        e_cyc = cyc;
        $display("load: accepted at cycle %0d", e_cyc);
    endtask

    task automatic run_until_idle(input int max, output int first_v, output int end_cyc);
        logic done;
        done = 1'b0;
        first_v = -1;
        end_cyc = -1;
        for (int n = 0; n < max && !done; n++) begin
            @(negedge clk);
            if (ch_valid && first_v < 0) first_v = cyc;
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                end_cyc = cyc;
            end
        end
        chk("idle_reached", 32'(done), 32'd1);
    endtask

    initial begin
        int e, fv, ec;
        logic [NB-1:0] d;
        logic found;

        rst = 1'b1;
        load_valid = 1'b0;
        load_data = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ch_valid", 32'(ch_valid), 32'd0);
        chk("rst_ch_data", 32'(ch_data), 32'd0);
        chk("rst_ch_last", 32'(ch_last), 32'd0);
        chk("rst_sent", 32'(sent), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_load_ready", 32'(load_ready), 32'd1);

        // "hello": 75 leading NULs, full-rate consumer
        push_str("hello");
        do_load(pack_str("hello"), e);
        run_until_idle(200, fv, ec);
        chk("hello_latency", 32'(fv - e), 32'd76);
        chk("hello_sent", 32'(sent), 32'd5);
        chk("hello_load_ready", 32'(load_ready), 32'd1);
        chk("hello_ch_valid_off", 32'(ch_valid), 32'd0);

        // Same string with backpressure
        push_str("hello");
        bp_en = 1'b1;
        bp_ph = 0;
        do_load(pack_str("hello"), e);
        run_until_idle(300, fv, ec);
        bp_en = 1'b0;
        chk("bp_sent", 32'(sent), 32'd5);

        // All-NUL string: no beats, idle after NCHARS cycles
        do_load('0, e);
        run_until_idle(200, fv, ec);
        chk("nul_no_valid", 32'(fv), 32'hFFFF_FFFF);
        chk("nul_idle_time", 32'(ec - e), 32'd80);
        chk("nul_sent", 32'(sent), 32'd0);

        // Full 80-character string
        for (int i = 0; i < NCHARS; i++) begin
            d[i * CW +: CW] = 8'h41;
            exp_q.push_back({1'(i == NCHARS - 1), 8'h41});
        end
        do_load(d, e);
        run_until_idle(300, fv, ec);
        chk("full_latency", 32'(fv - e), 32'd1);
        chk("full_sent", 32'(sent), 32'd80);

        // Embedded NUL is emitted, only leading padding skipped
        d = '0;
        d[2 * CW +: CW] = 8'h41;
        d[0 * CW +: CW] = 8'h42;
        exp_q.push_back({1'b0, 8'h41});
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b1, 8'h42});
        do_load(d, e);
        run_until_idle(200, fv, ec);
        chk("emb_sent", 32'(sent), 32'd3);

        // load_valid held with different data while busy: ignored until IDLE
        push_str("hello");
        push_str("BYE");
        do_load(pack_str("hello"), e);
        load_data  = pack_str("BYE");
        load_valid = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (!busy) found = 1'b1;
        end
        chk("hold_idle_seen", 32'(found), 32'd1);
        chk("hold_idle_load_ready", 32'(load_ready), 32'd1);
        chk("hold_first_sent", 32'(sent), 32'd5);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        chk("hold_second_busy", 32'(busy), 32'd1);
        run_until_idle(200, fv, ec);
        chk("hold_second_sent", 32'(sent), 32'd3);

        // Reset during the 3rd beat of "hello"
        exp_q.push_back({1'b0, 8'h68});
        exp_q.push_back({1'b0, 8'h65});
        exp_q.push_back({1'b0, 8'h6C});
        do_load(pack_str("hello"), e);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (ch_valid && ch_data == 8'h6C) found = 1'b1;
        end
        chk("midrst_third_beat_seen", 32'(found), 32'd1);
        chk("midrst_sent_before", 32'(sent), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_ch_valid", 32'(ch_valid), 32'd0);
        chk("midrst_ch_data", 32'(ch_data), 32'd0);
        chk("midrst_ch_last", 32'(ch_last), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_load_ready", 32'(load_ready), 32'd0);
        chk("midrst_sent", 32'(sent), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk("after_rst_load_ready", 32'(load_ready), 32'd1);
        push_str("hi");
        do_load(pack_str("hi"), e);
        run_until_idle(200, fv, ec);
        chk("hi_latency", 32'(fv - e), 32'd79);
        chk("hi_sent", 32'(sent), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
